// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Data-memory end of the AR address path. Accepts one word request at a time
//   (read or write), waits a fixed access latency, performs the access on an
//   internal array and reports completion with a single-cycle done pulse.
//   Out-of-range addresses and simultaneous read+write requests complete with
//   an error flag instead of touching the array or the read-data register.
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   rst_n     in   asynchronous active-low reset
//   i_dmaddr  in   word address from AR (ADDR_W bits)
//   i_din     in   write data from DR (DATA_W bits)
//   i_rd      in   read request, sampled only while idle
//   i_wr      in   write request, sampled only while idle
//   o_dout    out  registered read data, holds between reads
//   o_done    out  one-cycle completion pulse
//   o_busy    out  high whenever a request is in flight
//   o_err     out  qualifies o_done; high only in the response cycle
module data_memory_responder #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_dmaddr,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_rd,
  input  logic              i_wr,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_err
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Depth widened by one bit so the range compare never truncates DEPTH.
  localparam logic [ADDR_W:0] DepthExt = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0] CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_next;
  logic [DATA_W-1:0] r_din;
  logic [DATA_W-1:0] w_din_next;
  logic              r_rd;
  logic              w_rd_next;
  logic              r_wr;
  logic              w_wr_next;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] w_dout_next;
  logic              r_done;
  logic              w_done_next;
  logic              r_err;
  logic              w_err_next;

  logic              w_mem_we;
  logic              w_req_err;
  logic [IdxW-1:0]   w_idx;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Only the low index bits address the array; the range check uses the full
  // latched address so high addresses never alias onto low words.
  assign w_idx     = r_addr[IdxW-1:0];
  assign w_req_err = ({1'b0, r_addr} >= DepthExt) || (r_rd && r_wr);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_addr_next  = r_addr;
    w_din_next   = r_din;
    w_rd_next    = r_rd;
    w_wr_next    = r_wr;
    w_dout_next  = r_dout;
    w_done_next  = r_done;
    w_err_next   = r_err;
    w_mem_we     = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_done_next = 1'b0;
        w_err_next  = 1'b0;
        if (i_rd || i_wr) begin
          w_addr_next  = i_dmaddr;
          w_din_next   = i_din;
          w_rd_next    = i_rd;
          w_wr_next    = i_wr;
          w_cnt_next   = CntInit;
          w_state_next = StAccess;
        end
      end
      StAccess: begin
        if (r_cnt != 4'd0) begin
          w_cnt_next = r_cnt - 4'd1;
        end else begin
          w_state_next = StResp;
          w_done_next  = 1'b1;
          w_err_next   = w_req_err;
          if (!w_req_err) begin
            if (r_wr) begin
              w_mem_we = 1'b1;
            end else begin
              w_dout_next = r_mem[w_idx];
            end
          end
        end
      end
      StResp: begin
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_din   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_addr  <= w_addr_next;
      r_din   <= w_din_next;
      r_rd    <= w_rd_next;
      r_wr    <= w_wr_next;
      r_dout  <= w_dout_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
    end
  end

  // Array is not reset. A write in flight when reset hits is dropped because
  // the async reset forces the FSM out of StAccess before the commit edge.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= r_din;
    end
  end

  assign o_dout = r_dout;
  assign o_done = r_done;
  assign o_err  = r_err;
  assign o_busy = (r_state != StIdle);

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  logic        clk;
  logic        rst_n;

  // Instance A: LATENCY=2
  logic [15:0] a_addr, a_din, a_dout;
  logic        a_rd, a_wr, a_done, a_busy, a_err;
  // Instance B: LATENCY=1
  logic [15:0] b_addr, b_din, b_dout;
  logic        b_rd, b_wr, b_done, b_busy, b_err;

  int n_tests;
  int n_fail;

  data_memory_responder #(
    .DATA_W (16),
    .ADDR_W (16),
    .DEPTH  (4096),
    .LATENCY(2)
  ) u_dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_dmaddr(a_addr),
    .i_din   (a_din),
    .i_rd    (a_rd),
    .i_wr    (a_wr),
    .o_dout  (a_dout),
    .o_done  (a_done),
    .o_busy  (a_busy),
    .o_err   (a_err)
  );

  data_memory_responder #(
    .DATA_W (16),
    .ADDR_W (16),
    .DEPTH  (4096),
    .LATENCY(1)
  ) u_dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_dmaddr(b_addr),
    .i_din   (b_din),
    .i_rd    (b_rd),
    .i_wr    (b_wr),
    .o_dout  (b_dout),
    .o_done  (b_done),
    .o_busy  (b_busy),
    .o_err   (b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One request on instance A. Inputs change at negedges; after the accept the
  // address/data are scrambled to show they are latched. lat counts negedges
  // after the accept edge until done is seen (-1 on timeout).
  task automatic op_a(input logic rd, input logic wr, input logic [15:0] addr,
                      input logic [15:0] din, output int lat, output logic busy0,
                      output logic err, output logic [15:0] dout,
                      output logic done_after);
    a_rd   = rd;
    a_wr   = wr;
    a_addr = addr;
    a_din  = din;
    @(negedge clk);
    busy0  = a_busy;
    a_rd   = 1'b0;
    a_wr   = 1'b0;
    a_addr = 16'hFFFF;
    a_din  = 16'h0000;
    lat    = -1;
    err    = 1'bx;
    dout   = 16'hxxxx;
    for (int i = 0; i < 20; i++) begin
      if (a_done) begin
        lat  = i;
        err  = a_err;
        dout = a_dout;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    done_after = a_done;
  endtask

  task automatic op_b(input logic rd, input logic wr, input logic [15:0] addr,
                      input logic [15:0] din, output int lat);
    b_rd   = rd;
    b_wr   = wr;
    b_addr = addr;
    b_din  = din;
    @(negedge clk);
    b_rd = 1'b0;
    b_wr = 1'b0;
    lat  = -1;
    for (int i = 0; i < 20; i++) begin
      if (b_done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_rd = 1'b0; a_wr = 1'b0; a_addr = 16'h0; a_din = 16'h0;
    b_rd = 1'b0; b_wr = 1'b0; b_addr = 16'h0; b_din = 16'h0;
    #2;
    n_tests++;
    if ({a_done, a_busy, a_err, a_dout} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_a: got done=%b busy=%b err=%b dout=%h want all 0",
               a_done, a_busy, a_err, a_dout);
    end
    n_tests++;
    if ({b_done, b_busy, b_err, b_dout} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_b: got done=%b busy=%b err=%b dout=%h want all 0",
               b_done, b_busy, b_err, b_dout);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat; logic busy0, err, da; logic [15:0] dout;
    op_a(1'b0, 1'b1, 16'h0010, 16'hBEEF, lat, busy0, err, dout, da);
    n_tests++;
    if (busy0 !== 1'b1) begin
      n_fail++; $display("FAIL wr_busy: got %b want 1", busy0);
    end
    n_tests++;
    if (lat !== 2 || err !== 1'b0) begin
      n_fail++; $display("FAIL wr_done: got lat=%0d err=%b want lat=2 err=0", lat, err);
    end
    n_tests++;
    if (da !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_pulse: got done=%b busy=%b after resp want 0 0", da, a_busy);
    end
    op_a(1'b1, 1'b0, 16'h0010, 16'h0000, lat, busy0, err, dout, da);
    n_tests++;
    if (lat !== 2 || err !== 1'b0 || dout !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL rd_beef: got lat=%0d err=%b dout=%h want 2 0 beef", lat, err, dout);
    end
  endtask

  task automatic test_ignore_in_access();
    int lat; logic busy0, err, da; logic [15:0] dout;
    int ndone; logic [15:0] seen;
    op_a(1'b0, 1'b1, 16'h0020, 16'hCAFE, lat, busy0, err, dout, da);
    ndone = 0;
    seen  = 16'h0000;
    a_rd   = 1'b1;
    a_addr = 16'h0020;
    @(negedge clk);
    // Now in ACCESS: a short read pulse at a different address must be ignored.
    a_addr = 16'h0010;
    @(negedge clk);
    if (a_done) begin ndone++; seen = a_dout; end
    a_rd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_done) begin ndone++; seen = a_dout; end
    end
    n_tests++;
    if (ndone !== 1) begin
      n_fail++; $display("FAIL ignore_count: got %0d done pulses want 1", ndone);
    end
    n_tests++;
    if (seen !== 16'hCAFE) begin
      n_fail++; $display("FAIL ignore_data: got dout=%h want cafe", seen);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic busy0, err, da; logic [15:0] dout;
    op_a(1'b0, 1'b1, 16'h0000, 16'h0A0A, lat, busy0, err, dout, da);
    op_a(1'b0, 1'b1, 16'h1000, 16'h1234, lat, busy0, err, dout, da);
    n_tests++;
    if (lat !== 2 || err !== 1'b1) begin
      n_fail++; $display("FAIL oor_wr: got lat=%0d err=%b want 2 1", lat, err);
    end
    op_a(1'b1, 1'b0, 16'h0000, 16'h0000, lat, busy0, err, dout, da);
    n_tests++;
    if (err !== 1'b0 || dout !== 16'h0A0A) begin
      n_fail++; $display("FAIL no_alias: got err=%b dout=%h want 0 0a0a", err, dout);
    end
    op_a(1'b1, 1'b0, 16'hF000, 16'h0000, lat, busy0, err, dout, da);
    n_tests++;
    if (lat !== 2 || err !== 1'b1 || dout !== 16'h0A0A) begin
      n_fail++;
      $display("FAIL oor_rd: got lat=%0d err=%b dout=%h want 2 1 0a0a", lat, err, dout);
    end
  endtask

  task automatic test_rd_wr_both();
    int lat; logic busy0, err, da; logic [15:0] dout;
    op_a(1'b0, 1'b1, 16'h0005, 16'h7777, lat, busy0, err, dout, da);
    op_a(1'b1, 1'b0, 16'h0005, 16'h0000, lat, busy0, err, dout, da);
    op_a(1'b1, 1'b1, 16'h0005, 16'hAAAA, lat, busy0, err, dout, da);
    n_tests++;
    if (lat !== 2 || err !== 1'b1 || dout !== 16'h7777) begin
      n_fail++;
      $display("FAIL both_err: got lat=%0d err=%b dout=%h want 2 1 7777", lat, err, dout);
    end
    op_a(1'b1, 1'b0, 16'h0005, 16'h0000, lat, busy0, err, dout, da);
    n_tests++;
    if (err !== 1'b0 || dout !== 16'h7777) begin
      n_fail++; $display("FAIL both_mem: got err=%b dout=%h want 0 7777", err, dout);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic busy0, err, da; logic [15:0] dout;
    op_a(1'b0, 1'b1, 16'h0003, 16'h1111, lat, busy0, err, dout, da);
    op_a(1'b1, 1'b0, 16'h0000, 16'h0000, lat, busy0, err, dout, da);
    a_wr   = 1'b1;
    a_addr = 16'h0003;
    a_din  = 16'h5555;
    @(negedge clk);
    a_wr = 1'b0;
    n_tests++;
    if (a_busy !== 1'b1 || a_dout !== 16'h0A0A) begin
      n_fail++;
      $display("FAIL abort_pre: got busy=%b dout=%h want 1 0a0a", a_busy, a_dout);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({a_done, a_busy, a_err, a_dout} !== 19'h0) begin
      n_fail++;
      $display("FAIL abort_rst: got done=%b busy=%b err=%b dout=%h want all 0",
               a_done, a_busy, a_err, a_dout);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op_a(1'b1, 1'b0, 16'h0003, 16'h0000, lat, busy0, err, dout, da);
    n_tests++;
    if (lat !== 2 || err !== 1'b0 || dout !== 16'h1111) begin
      n_fail++;
      $display("FAIL abort_mem: got lat=%0d err=%b dout=%h want 2 0 1111", lat, err, dout);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] exp_d [3];
    int got;
    exp_d[0] = 16'h0101;
    exp_d[1] = 16'h0202;
    exp_d[2] = 16'h0303;
    for (int k = 0; k < 3; k++) begin
      op_b(1'b0, 1'b1, 16'(k), exp_d[k], lat);
      n_tests++;
      if (lat !== 1) begin
        n_fail++; $display("FAIL b_wr_lat%0d: got %0d want 1", k, lat);
      end
    end
    b_rd   = 1'b1;
    b_addr = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      got = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (b_done) begin
          got = 1;
          break;
        end
      end
      n_tests++;
      if (got !== 1 || b_err !== 1'b0 || b_dout !== exp_d[k]) begin
        n_fail++;
        $display("FAIL b2b_rd%0d: got done=%0d err=%b dout=%h want 1 0 %h",
                 k, got, b_err, b_dout, exp_d[k]);
      end
      b_addr = 16'(k + 1);
      if (k == 2) b_rd = 1'b0;
      @(negedge clk);
      n_tests++;
      if (b_done !== 1'b0) begin
        n_fail++; $display("FAIL b2b_pulse%0d: got done=%b want 0", k, b_done);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_write_read();
    test_ignore_in_access();
    test_out_of_range();
    test_rd_wr_both();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
